// File: rtl/clip_arbiter.sv
// Round-robin arbiter sharing one floating-point clip datapath between N requesters.
// Results leave through a single registered stage tagged with the requester index.

module fp_cmp #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter bit    GREATER   = 1'b1
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    output logic            res_o
);
    localparam int EXP_BITS = (PRECISION == "SINGLE")   ? 8  :
                              (PRECISION == "DOUBLE")   ? 11 :
                              (PRECISION == "BFLOAT16") ? 8  : 5;
    localparam int MAN_BITS = BITS - 1 - EXP_BITS;

    function automatic logic is_nan(input logic [BITS-1:0] x);
        return (&x[BITS-2 -: EXP_BITS]) && (|x[MAN_BITS-1:0]);
    endfunction

    // Maps sign-magnitude onto an unsigned total order; -0 folds onto +0.
    function automatic logic [BITS-1:0] order_key(input logic [BITS-1:0] x);
        logic [BITS-1:0] k;
        if (x[BITS-2:0] == '0) begin
            k = {1'b1, {(BITS-1){1'b0}}};
        end else if (x[BITS-1]) begin
            k = ~x;
        end else begin
            k = {1'b1, x[BITS-2:0]};
        end
        return k;
    endfunction

    logic [BITS-1:0] key_a_s;
    logic [BITS-1:0] key_b_s;
    logic            unordered_s;
    logic            ordered_res_s;

    assign key_a_s       = order_key(a_i);
    assign key_b_s       = order_key(b_i);
    assign unordered_s   = is_nan(a_i) | is_nan(b_i);
    assign ordered_res_s = GREATER ? (key_a_s > key_b_s) : (key_a_s < key_b_s);
    assign res_o         = unordered_s ? 1'b0 : ordered_res_s;
endmodule

module greater_than #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    output logic            gt_o
);
    fp_cmp #(.BITS(BITS), .PRECISION(PRECISION), .GREATER(1'b1)) u_cmp (
        .a_i   (a_i),
        .b_i   (b_i),
        .res_o (gt_o)
    );
endmodule

module less_than #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    output logic            lt_o
);
    fp_cmp #(.BITS(BITS), .PRECISION(PRECISION), .GREATER(1'b0)) u_cmp (
        .a_i   (a_i),
        .b_i   (b_i),
        .res_o (lt_o)
    );
endmodule

module clip #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] min_i,
    input  logic [BITS-1:0] max_i,
    output logic [BITS-1:0] res_o
);
    logic above_min_s;
    logic below_max_s;

    greater_than #(.BITS(BITS), .PRECISION(PRECISION)) u_greater_than (
        .a_i  (a_i),
        .b_i  (min_i),
        .gt_o (above_min_s)
    );

    less_than #(.BITS(BITS), .PRECISION(PRECISION)) u_less_than (
        .a_i  (a_i),
        .b_i  (max_i),
        .lt_o (below_max_s)
    );

    // NaN and a == min both fail the strict compare and fall through to min.
    always_comb begin
        if (above_min_s && below_max_s) begin
            res_o = a_i;
        end else if (above_min_s) begin
            res_o = max_i;
        end else begin
            res_o = min_i;
        end
    end
endmodule

module clip_arbiter #(
    parameter int              BITS      = 16,
    parameter string           PRECISION = "HALF",
    parameter int              N         = 4,
    parameter logic [BITS-1:0] MIN_INIT  = 16'hFC00,
    parameter logic [BITS-1:0] MAX_INIT  = 16'h7C00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [BITS-1:0]      cfg_min,
    input  logic [BITS-1:0]      cfg_max,
    input  logic [N-1:0]         req_valid,
    input  logic [N*BITS-1:0]    req_data,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [BITS-1:0]      out_data,
    output logic [$clog2(N)-1:0] out_id,
    input  logic                 out_ready
);
    localparam int ID_BITS = $clog2(N);

    logic [BITS-1:0]    min_q, min_d;
    logic [BITS-1:0]    max_q, max_d;
    logic [ID_BITS-1:0] last_q, last_d;
    logic               out_valid_q, out_valid_d;
    logic [BITS-1:0]    out_data_q, out_data_d;
    logic [ID_BITS-1:0] out_id_q, out_id_d;

    logic               free_s;
    logic               grant_any_s;
    logic               grant_s;
    logic [ID_BITS-1:0] grant_idx_s;
    logic [ID_BITS-1:0] cand_s;
    logic [BITS-1:0]    sel_data_s;
    logic [BITS-1:0]    clip_res_s;

    // Search starts just after the previous winner so every requester is reached within N grants.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int k = 1; k <= N; k++) begin
            cand_s = ID_BITS'((int'(last_q) + k) % N);
            if (!grant_any_s && req_valid[cand_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_any_s = grant_any_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    assign free_s     = !out_valid_q || out_ready;
    assign grant_s    = free_s && grant_any_s;
    assign req_ready  = grant_s ? ({{(N-1){1'b0}}, 1'b1} << grant_idx_s) : {N{1'b0}};
    assign sel_data_s = req_data[int'(grant_idx_s)*BITS +: BITS];

    clip #(.BITS(BITS), .PRECISION(PRECISION)) u_clip (
        .a_i   (sel_data_s),
        .min_i (min_q),
        .max_i (max_q),
        .res_o (clip_res_s)
    );

    // Next state: the window update never affects the grant clipped in the same cycle.
    always_comb begin
        min_d       = min_q;
        max_d       = max_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (cfg_we) begin
            min_d = cfg_min;
            max_d = cfg_max;
        end else begin
            min_d = min_q;
            max_d = max_q;
        end
        if (grant_s) begin
            out_valid_d = 1'b1;
            out_data_d  = clip_res_s;
            out_id_d    = grant_idx_s;
            last_d      = grant_idx_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset discarding any held result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_q       <= MIN_INIT;
            max_q       <= MAX_INIT;
            last_q      <= ID_BITS'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            min_q       <= min_d;
            max_q       <= max_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
endmodule

// File: doc/clip_arbiter.md
# clip_arbiter

Round-robin arbiter that shares one `clip` datapath instance, and its `greater_than`/`less_than` comparators, between N requesters. Each requester presents an operand over a valid/ready handshake. The block clamps the winning operand to a shared `[min, max]` window held in internal configuration registers. It returns the result through a single registered output stage tagged with the requester index. It sits between per-lane producers, for example activation units, and a common downstream consumer.

## Interface
- `BITS`, 16, operand width; passed to `clip`.
- `PRECISION`, "HALF", number format; passed to `clip`.
- `N`, 4, number of requesters, 2..16; `ID_BITS = $clog2(N)` is a localparam.
- `MIN_INIT`, 16'hFC00, reset value of the min register (-inf, half).
- `MAX_INIT`, 16'h7C00, reset value of the max register (+inf, half).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: writes `cfg_min`/`cfg_max` into the window registers.
- `cfg_min` in BITS: new lower bound.
- `cfg_max` in BITS: new upper bound.
- `req_valid` in N: per-requester operand valid.
- `req_data` in N*BITS: operands; requester i occupies bits `[i*BITS +: BITS]`.
- `req_ready` out N: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `out_valid` out 1: the result register holds data.
- `out_data` out BITS: clipped result.
- `out_id` out ID_BITS: index of the requester that produced `out_data`.
- `out_ready` in 1: consumer accepts the result when `out_valid & out_ready`.

## Operation
- Window registers `min_q`, `max_q` load on `cfg_we` at the clock edge. No ordering check is applied; if min > max, the result follows `clip` semantics exactly.
- The arbiter can grant when the output stage is free: `free = !out_valid | out_ready`.
- When `free` and any `req_valid` is set, the arbiter grants exactly one requester, chosen round-robin.
  - Priority order starts at `last_q + 1` and wraps modulo N.
  - `last_q` updates to the granted index.
- `req_ready` is 0 for all requesters when `!free` or no request is pending.
- `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and `last_q`.
- `req_ready` never depends on `req_data`.
- The granted operand is muxed into the single `clip` instance together with `min_q`/`max_q`. The `clip` output is captured into `out_data`, and the grant index into `out_id`.
- `out_valid` next state:
  - set on a grant;
  - else cleared on `out_valid & out_ready`;
  - else held.
- `out_data`/`out_id` stay stable while `out_valid & !out_ready`.
- Clip result:
  - `a` when a > min and a < max;
  - `max` when a > min and !(a < max);
  - `min` otherwise, which includes a == min and NaN per comparator results.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_id` 0, `min_q` MIN_INIT, `max_q` MAX_INIT, `last_q` N-1 (requester 0 has first priority).
- Reset asserted mid-transfer discards the held result immediately. No result is replayed.
- Latency: operand granted at edge t appears on `out_data` with `out_valid` = 1 after edge t.
- Throughput: one result per cycle while `out_ready` = 1 (grant and drain in the same cycle).
- `cfg_we` in the same cycle as a grant: that grant is clipped with the old window; later grants use the new window.
- Requester i dropping `req_valid` without a grant: legal; no state change.
- All N requesting continuously with `out_ready` = 1: grants rotate 0,1,…,N-1,0 with no gaps.
- The combinational path req_valid → req_ready passes through the arbiter only, not through `clip`. The clip path is req_data → mux → clip → out_data register.

## Test plan
- Reset, then `cfg_we` with min=3800 (0.5) and max=4000 (2.0); requester 0 sends 3C00 -> next cycle `out_valid`=1, `out_data`=3C00, `out_id`=0.
- Same window; requester 2 sends 4200 (3.0), then BC00 (-1.0) -> results 4000 then 3800, both with `out_id`=2; an input equal to 3800 -> 3800.
- All 4 requesters valid continuously, `out_ready`=1 -> grant order 0,1,2,3,0,…; one result every cycle; each requester sees exactly one `req_ready` pulse per 4 cycles.
- `out_ready` held 0 for 3 cycles with all requesters valid -> `req_ready`=0 throughout; `out_data`/`out_id` frozen; on release, the next grant goes to `last_q`+1 the same cycle.
- `cfg_we` (max=3C00) in the same cycle requester 1 is granted 4000 -> result 4000 (old max); the next grant of 4000 returns 3C00.
- Assert `reset` asynchronously (between edges) while `out_valid`=1 -> `out_valid` drops before the next edge; window returns to FC00/7C00; the first grant after reset goes to requester 0.
